// File: rtl/twoscomp_pkg.sv
// Shared definitions for the two's-complement serial encode/decode blocks.
//   state_t  : controller states of the serial converters
//   TC_WIDTH : default operand width of the complex multiplier datapath
package twoscomp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int TC_WIDTH = 16;

endpackage

// File: rtl/serial_negate_cell.sv
// One-bit serial negation cell: copy bits up to and including the first one,
// complement every bit after it (only when neg is set).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear the seen-one flag (start of a new operand)
//   en         : advance the cell by one bit
//   neg        : operand is negative, apply the complement rule
//   b          : current input bit (LSB first)
//   o          : output bit for this cycle (combinational from b)
module serial_negate_cell (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic neg,
    input  logic b,
    output logic o
);

    logic seen_one_q;
    logic seen_one_d;

    always_comb begin
        seen_one_d = seen_one_q;
        if (clr) begin
            seen_one_d = 1'b0;
        end else if (en) begin
            seen_one_d = seen_one_q | b;
        end
    end

    // The first one itself is copied: only bits after it see seen_one_q=1.
    assign o = (neg & seen_one_q) ? ~b : b;

    always_ff @(posedge clk) begin
        if (reset) begin
            seen_one_q <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
        end
    end

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start, din : load request and operand, sampled only in IDLE
//   busy       : high whenever the controller is not IDLE
//   out_valid  : result available (DONE state)
//   out_ready  : consumer accepts the result
//   sign, mag  : sign flag and unsigned magnitude of the accepted operand
//   dbg_state  : current controller state (state_t encoding)
//
// Handshake: the result transfers on a rising edge where out_valid and
// out_ready are both high. out_valid, sign and mag stay stable until that
// transfer; out_ready may be high before out_valid without effect.
module twos_to_signmag_serial
    import twoscomp_pkg::*;
#(
    parameter int WIDTH = TC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [WIDTH-1:0] mag,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sign_q,  sign_d;
    logic [WIDTH-1:0] mag_q,   mag_d;

    logic cell_clr;
    logic cell_en;
    logic cell_o;

    serial_negate_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .clr   (cell_clr),
        .en    (cell_en),
        .neg   (sign_q),
        .b     (shreg_q[0]),
        .o     (cell_o)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        cell_clr = 1'b0;
        cell_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d  = din;
                    sign_d   = din[WIDTH-1];
                    cnt_d    = '0;
                    cell_clr = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                cell_en = 1'b1;
                // Rotate right, substituting the converted bit at the MSB so
                // that after WIDTH steps the register holds the magnitude.
                shreg_d = {cell_o, shreg_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    mag_d   = {cell_o, shreg_q[WIDTH-1:1]};
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign sign      = sign_q;
    assign mag       = mag_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
module tb_twos_to_signmag_serial;
  import twoscomp_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] din;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic         sign;
  logic [W-1:0] mag;
  logic [1:0]   dbg_state;

  int n_tests;
  int n_fail;
  int cycle_cnt;

  logic [W:0] exp_q[$];   // {sign, mag}
  int         acc_q[$];   // cycle count right after the accept edge

  twos_to_signmag_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .mag       (mag),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] d);
    logic [W-1:0] m;
    m = d[W-1] ? (~d + 1'b1) : d;
    return {d[W-1], m};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // ---------------- driver ----------------
  // dly = cycles of backpressure after out_valid; dly==0 raises out_ready early.
  // inj = issue ignored start requests during SHIFT and at the handshake edge.
  task automatic run_op(input logic [W-1:0] d, input int dly, input bit inj,
                        input logic [W:0] exp_v);
    int n;
    wait_idle();
    din   = d;
    start = 1'b1;
    exp_q.push_back(exp_v);
    @(negedge clk);
    start = 1'b0;
    acc_q.push_back(cycle_cnt);
    din   = W'($urandom);
    if (inj) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      din   = 16'h1234;
      repeat (2) @(negedge clk);
      start = 1'b0;
    end
    if (dly == 0) out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("valid_timeout", 32'(out_valid), 32'd1);
      exp_q.delete();
      acc_q.delete();
      out_ready = 1'b0;
      return;
    end
    repeat (dly) @(negedge clk);
    out_ready = 1'b1;
    if (inj) start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (inj) begin
      check("start_ignored_in_done", 32'(busy), 32'd0);
      start = 1'b0;
    end
  endtask

  task automatic reset_mid_op();
    wait_idle();
    din   = 16'hFFF0;
    start = 1'b1;
    @(negedge clk);            // accept edge E0 passed
    start = 1'b0;
    repeat (7) @(negedge clk); // E1..E7
    reset = 1'b1;              // sampled on shift edge E8
    @(negedge clk);
    check("rst_mid_busy",  32'(busy),      32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_mag",   32'(mag),       32'd0);
    check("rst_mid_sign",  32'(sign),      32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_valid;
  logic         prev_hs;
  logic [W-1:0] held_mag;
  logic         held_sign;

  initial begin
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    held_mag   = '0;
    held_sign  = 1'b0;
  end

  always @(negedge clk) begin
    logic [W:0] e;
    int a;
    #2;
    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          a = acc_q.pop_front();
          check("latency_edges", 32'(cycle_cnt - a + 1), 32'(W + 1));
        end
      end
      if (out_valid && prev_valid) begin
        check("stable_mag",  32'(mag),  32'(held_mag));
        check("stable_sign", 32'(sign), 32'(held_sign));
      end
      if (prev_valid && !out_valid && !prev_hs)
        check("valid_dropped", 32'(out_valid), 32'd1);
      prev_hs = 1'b0;
      if (out_valid && out_ready) begin
        prev_hs = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_sign", 32'(sign), 32'(e[W]));
          check("result_mag",  32'(mag),  32'(e[W-1:0]));
        end
      end
      held_mag   = mag;
      held_sign  = sign;
      prev_valid = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] r;
    n_tests   = 0;
    n_fail    = 0;
    cycle_cnt = 0;
    reset     = 1'b1;
    start     = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy",  32'(busy),      32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_sign",  32'(sign),      32'd0);
    check("reset_mag",   32'(mag),       32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    // directed vectors, expected values computed by hand
    run_op(16'h0005, 1, 1'b0, {1'b0, 16'h0005});
    run_op(16'hFFFB, 2, 1'b0, {1'b1, 16'h0005});
    run_op(16'hFFFF, 0, 1'b0, {1'b1, 16'h0001});
    run_op(16'h0000, 1, 1'b0, {1'b0, 16'h0000});
    run_op(16'h8000, 0, 1'b0, {1'b1, 16'h8000});
    run_op(16'h7FFF, 3, 1'b0, {1'b0, 16'h7FFF});
    // second start ignored while busy, result from the first operand
    run_op(16'hFFFB, 1, 1'b1, {1'b1, 16'h0005});
    // ten cycles of backpressure
    run_op(16'hABCD, 10, 1'b0, {1'b1, 16'h5433});
    // reset mid-shift, then a clean rerun
    reset_mid_op();
    run_op(16'hFFF0, 0, 1'b0, {1'b1, 16'h0010});

    // random sweep
    for (int i = 0; i < 1000; i++) begin
      r = W'($urandom);
      run_op(r, $urandom_range(0, 4), 1'b0, model(r));
    end

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("acc_q_empty", 32'(acc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/twos_to_signmag_serial.md
# twos_to_signmag_serial

Bit-serial decoder from two's complement to sign-magnitude. It is the receive side of the complex multiplier's serial negation path: it takes a 16-bit two's-complement operand and recovers the sign flag and unsigned magnitude. Negative operands use the serial copy-until-first-one, then complement-the-rest rule, one bit per clock. Results go to the multiplier datapath over a valid/ready handshake.

## Interface
- `WIDTH`, default 16: operand width in bits; must be ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request to load `din`; sampled only in IDLE.
- `din` in WIDTH: two's-complement operand.
- `busy` out 1: high whenever state ≠ IDLE.
- `out_valid` out 1: result available; high only in DONE.
- `out_ready` in 1: consumer accepts the result.
- `sign` out 1: `din[WIDTH-1]` of the accepted operand.
- `mag` out WIDTH: unsigned magnitude |din|.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: processes one bit per cycle, LSB first.
  - DONE: holds the result until handshake.
- IDLE with `start`=1:
  - Load the shift register ← `din`, `sign` ← `din[WIDTH-1]`, `seen_one` ← 0, counter ← 0.
  - Next state SHIFT.
- IDLE with `start`=0: stay in IDLE.
- SHIFT, each cycle, with b = `shreg[0]`:
  - Output bit o = (`sign` & `seen_one`) ? ~b : b.
  - `shreg` ← {o, `shreg[WIDTH-1:1]`} (rotate right with substitution).
  - `seen_one` ← `seen_one` | b.
  - Counter increments.
  - When the counter = WIDTH-1 on this cycle, go to DONE.
- Positive operands (`sign`=0) pass through unchanged. Latency is constant regardless of sign.
- DONE:
  - `mag` = `shreg`; `out_valid`=1.
  - On `out_valid` & `out_ready`, go to IDLE.
  - `mag` and `sign` stay stable until the next load.
- Width rule: `mag` is WIDTH bits unsigned, so the most negative input decodes without overflow. 0x8000 gives `mag`=0x8000, `sign`=1.
- `start` is ignored while `busy`=1, including the handshake cycle in DONE. No queueing.
- `din` is sampled only on the accept edge. Later changes to `din` have no effect.

## Timing
- Reset values:
  - state IDLE.
  - `busy`=0, `out_valid`=0, `sign`=0, `mag`=0.
  - Counter 0, `seen_one` 0.
- `reset` takes priority over every other input, including mid-SHIFT and in DONE. The next cycle is IDLE, and the partial result is discarded.
- Latency: `start` sampled on edge E0 gives `busy`=1 after E0. The WIDTH shift edges are E1..E16 for WIDTH=16. `out_valid`=1 after E16, i.e. WIDTH+1 edges after accept.
- Throughput: one operand per WIDTH+2 cycles at best:
  - accept edge,
  - WIDTH shift edges,
  - handshake edge,
  - `start` re-sampled in IDLE.
- `out_ready` may be held high early. A transfer occurs on the first edge in DONE.
- With backpressure (`out_ready`=0), DONE holds indefinitely and outputs stay stable.
- `out_valid` never drops without a handshake, except on `reset`.

## Structure
- Package `twoscomp_pkg`:
  - `state_t` enum {IDLE, SHIFT, DONE}.
  - Constant `TC_WIDTH` = 16.
  - Shared with the encoder-side blocks.
- Sub-module `serial_negate_cell`:
  - Inputs: `clk`, `reset`, `clr`, `en`, `neg`, `b`.
  - Output: `o`.
  - Holds the `seen_one` flop and the copy/complement mux.
  - Reusable by any future serial negator.
- Top level contains:
  - the FSM,
  - a counter of $clog2(WIDTH) bits,
  - the rotate shift register,
  - output registers.

## Test plan
- Positive value: `din`=0x0005, `start` pulse → after 17 edges, `out_valid`=1, `sign`=0, `mag`=0x0005.
- Negative value: `din`=0xFFFB → `sign`=1, `mag`=0x0005.
- `din`=0xFFFF → `mag`=0x0001.
- `din`=0x0000 → `mag`=0, `sign`=0.
- Boundary: `din`=0x8000 → `sign`=1, `mag`=0x8000.
- `din`=0x7FFF → `sign`=0, `mag`=0x7FFF.
- Busy/backpressure:
  - Second `start` with `din`=0x1234 during SHIFT is ignored; the result still reflects the first operand.
  - Holding `out_ready`=0 for 10 cycles keeps `out_valid`=1 and `mag` stable.
- Reset mid-operation:
  - Assert `reset` on shift edge 8 of `din`=0xFFF0 → next cycle `busy`=0, `out_valid`=0, `mag`=0, `sign`=0.
  - A fresh `start` with `din`=0xFFF0 then gives `mag`=0x0010.
- Random sweep: 1000 random `din` values with random `out_ready` delays; compare against reference model |din| and the sign bit; check latency is exactly WIDTH+1 edges.
